// File: rtl/rename_map_table.sv
// Speculative register alias table: maps architectural to physical registers,
// seeds and drives the physical free list, and supports one level of rename undo.
module rename_map_table #(
  parameter int NUM_ARCH_REGS = 32,
  parameter int NUM_PHYS_REGS = 64,
  parameter int PHYS_W        = $clog2(NUM_PHYS_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rename_valid,
  input  logic [4:0]        rename_rs1,
  input  logic [4:0]        rename_rs2,
  input  logic [4:0]        rename_rd,
  input  logic              rename_uses_rd,
  output logic              rename_ready,
  output logic [PHYS_W-1:0] phys_rs1,
  output logic [PHYS_W-1:0] phys_rs2,
  output logic [PHYS_W-1:0] phys_rd,
  output logic [PHYS_W-1:0] prev_phys_rd,
  input  logic              rollback,
  input  logic              retire_valid,
  input  logic [PHYS_W-1:0] retire_prev_phys_rd,
  output logic              fl_push,
  output logic              fl_potential_push,
  output logic [PHYS_W-1:0] fl_data_in,
  output logic              fl_pop,
  output logic              fl_rollback,
  input  logic [PHYS_W-1:0] fl_data_out,
  input  logic              fl_valid,
  output logic              init_done
);

  typedef enum logic {INIT, READY} state_e;

  // init_cnt is one bit wider than a physical index so it can reach NUM_PHYS_REGS.
  localparam logic [PHYS_W:0] SEED_FIRST = (PHYS_W+1)'(NUM_ARCH_REGS);
  localparam logic [PHYS_W:0] SEED_LAST  = (PHYS_W+1)'(NUM_PHYS_REGS - 1);
  localparam logic [PHYS_W:0] SEED_STEP  = (PHYS_W+1)'(1);

  state_e            state, state_next;
  logic [PHYS_W-1:0] map [NUM_ARCH_REGS];
  logic [PHYS_W:0]   init_cnt;
  logic [4:0]        last_rd;
  logic [PHYS_W-1:0] last_prev;
  logic              last_alloc;
  logic              alloc;
  logic              accept;

  // Lookups read the pre-update map, so rs == rd sees the old mapping.
  assign phys_rs1     = map[rename_rs1];
  assign phys_rs2     = map[rename_rs2];
  assign prev_phys_rd = map[rename_rd];
  assign alloc        = rename_uses_rd & (rename_rd != '0);
  assign phys_rd      = alloc ? fl_data_out : '0;
  assign accept       = rename_valid & rename_ready;

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    state_next        = state;
    rename_ready      = 1'b0;
    fl_push           = 1'b0;
    fl_potential_push = 1'b0;
    fl_data_in        = retire_prev_phys_rd;
    fl_pop            = 1'b0;
    fl_rollback       = 1'b0;
    init_done         = (state == READY);
    unique case (state)
      INIT: begin
        fl_push           = 1'b1;
        fl_potential_push = 1'b1;
        fl_data_in        = init_cnt[PHYS_W-1:0];
        if (init_cnt == SEED_LAST) state_next = READY;
      end
      READY: begin
        rename_ready      = ~rollback & (~alloc | fl_valid);
        fl_pop            = rename_valid & rename_ready & alloc;
        fl_rollback       = rollback & last_alloc;
        fl_push           = retire_valid & (retire_prev_phys_rd != '0);
        fl_potential_push = fl_push;
      end
      default: state_next = INIT;
    endcase
    // Hold every handshake low while reset is applied, whatever state we leave.
    if (rst) begin
      rename_ready      = 1'b0;
      fl_push           = 1'b0;
      fl_potential_push = 1'b0;
      fl_pop            = 1'b0;
      fl_rollback       = 1'b0;
      init_done         = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT;
      init_cnt   <= SEED_FIRST;
      last_rd    <= '0;
      last_prev  <= '0;
      last_alloc <= 1'b0;
      // NOTE: the map is reset to identity, so it must stay in flops rather than a RAM macro.
      for (int i = 0; i < NUM_ARCH_REGS; i++) map[i] <= PHYS_W'(i);
    end else begin
      state <= state_next;
      if (state == INIT) init_cnt <= init_cnt + SEED_STEP;
      if (fl_rollback) begin
        map[last_rd] <= last_prev;
        last_alloc   <= 1'b0;
      end else if (accept) begin
        if (alloc) begin
          map[rename_rd] <= fl_data_out;
          last_rd        <= rename_rd;
          last_prev      <= prev_phys_rd;
          last_alloc     <= 1'b1;
        end else begin
          last_alloc <= 1'b0;
        end
      end
    end
  end

  // Seeding owns the free-list write port; retire and rollback are illegal until it ends.
  init_quiet: assert property (@(posedge clk) disable iff (rst)
    (state == INIT) |-> !(rollback || retire_valid));

endmodule

// File: tb/tb_rename_map_table.sv
// Self-checking bench for rename_map_table: a FIFO stands in for the free list and
// an architectural-level model predicts every lookup and handshake.
module tb_rename_map_table;

  localparam int NA = 32;
  localparam int NP = 64;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          rename_valid, rename_uses_rd, rollback, retire_valid;
  logic [4:0]    rename_rs1, rename_rs2, rename_rd;
  logic [PW-1:0] retire_prev_phys_rd;
  logic          rename_ready, fl_push, fl_potential_push, fl_pop, fl_rollback, init_done;
  logic [PW-1:0] phys_rs1, phys_rs2, phys_rd, prev_phys_rd, fl_data_in, fl_data_out;
  logic          fl_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rename_map_table #(.NUM_ARCH_REGS(NA), .NUM_PHYS_REGS(NP), .PHYS_W(PW)) dut (
    .clk(clk), .rst(rst),
    .rename_valid(rename_valid), .rename_rs1(rename_rs1), .rename_rs2(rename_rs2),
    .rename_rd(rename_rd), .rename_uses_rd(rename_uses_rd), .rename_ready(rename_ready),
    .phys_rs1(phys_rs1), .phys_rs2(phys_rs2), .phys_rd(phys_rd), .prev_phys_rd(prev_phys_rd),
    .rollback(rollback), .retire_valid(retire_valid), .retire_prev_phys_rd(retire_prev_phys_rd),
    .fl_push(fl_push), .fl_potential_push(fl_potential_push), .fl_data_in(fl_data_in),
    .fl_pop(fl_pop), .fl_rollback(fl_rollback), .fl_data_out(fl_data_out),
    .fl_valid(fl_valid), .init_done(init_done)
  );

  // Free-list stand-in: circular FIFO whose read index can step back by one.
  logic [PW-1:0] fl_mem [32];
  logic [4:0]    fl_head, fl_tail;
  int            fl_count;

  assign fl_data_out = fl_mem[fl_head];
  assign fl_valid    = (fl_count != 0);

  always @(posedge clk) begin
    if (rst) begin
      fl_head  <= '0;
      fl_tail  <= '0;
      fl_count <= 0;
    end else begin
      if (fl_push) begin
        fl_mem[fl_tail] <= fl_data_in;
        fl_tail         <= fl_tail + 5'd1;
      end
      if (fl_pop) fl_head <= fl_head + 5'd1;
      else if (fl_rollback) fl_head <= fl_head - 5'd1;
      fl_count <= fl_count + int'(fl_push) - int'(fl_pop) + int'(fl_rollback);
    end
  end

  // Reference model: architectural map, seeding progress and one undo record.
  logic [PW-1:0] ref_map [NA];
  int            seed_done;
  bit            ref_ready;
  bit            undo_v;
  logic [4:0]    undo_rd;
  logic [PW-1:0] undo_prev;

  logic          exp_alloc, exp_ready, exp_pop, exp_rb, exp_push, exp_init_done;
  logic [PW-1:0] exp_din, exp_rs1, exp_rs2, exp_prev, exp_prd;

  always_comb begin
    exp_alloc     = rename_uses_rd && (rename_rd != 5'd0);
    exp_ready     = 1'b0;
    exp_pop       = 1'b0;
    exp_rb        = 1'b0;
    exp_push      = 1'b0;
    exp_din       = PW'(NA + seed_done);
    exp_init_done = ref_ready && !rst;
    if (!rst) begin
      if (!ref_ready) begin
        exp_push = 1'b1;
      end else begin
        exp_ready = !rollback && (!exp_alloc || fl_valid);
        exp_pop   = rename_valid && exp_ready && exp_alloc;
        exp_rb    = rollback && undo_v;
        exp_push  = retire_valid && (retire_prev_phys_rd != '0);
        exp_din   = retire_prev_phys_rd;
      end
    end
    exp_rs1  = ref_map[rename_rs1];
    exp_rs2  = ref_map[rename_rs2];
    exp_prev = ref_map[rename_rd];
    exp_prd  = exp_alloc ? fl_data_out : '0;
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NA; i++) ref_map[i] <= PW'(i);
      seed_done <= 0;
      ref_ready <= 1'b0;
      undo_v    <= 1'b0;
    end else if (!ref_ready) begin
      seed_done <= seed_done + 1;
      if (seed_done == NP - NA - 1) ref_ready <= 1'b1;
    end else if (rollback) begin
      if (undo_v) begin
        ref_map[undo_rd] <= undo_prev;
        undo_v           <= 1'b0;
      end
    end else if (rename_valid && exp_ready) begin
      if (exp_alloc) begin
        undo_v             <= 1'b1;
        undo_rd            <= rename_rd;
        undo_prev          <= ref_map[rename_rd];
        ref_map[rename_rd] <= fl_data_out;
      end else begin
        undo_v <= 1'b0;
      end
    end
  end

  task automatic idle();
    rename_valid = 0; rename_uses_rd = 0; rollback = 0; retire_valid = 0;
    rename_rs1 = 0; rename_rs2 = 0; rename_rd = 0; retire_prev_phys_rd = 0;
  endtask

  task automatic reset_and_seed();
    @(negedge clk); idle(); rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (NP - NA + 1) @(negedge clk);
  endtask

  task automatic test_reset();
    idle(); rst = 1; rename_rs1 = 5'd5; rename_rs2 = 5'd17; rename_rd = 5'd31;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (rename_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", rename_ready); end
    checks++; if (fl_push !== 1'b0 || fl_potential_push !== 1'b0) begin errors++; $display("FAIL reset_push: got %b/%b want 0/0", fl_push, fl_potential_push); end
    checks++; if (fl_pop !== 1'b0 || fl_rollback !== 1'b0) begin errors++; $display("FAIL reset_pop_rb: got %b/%b want 0/0", fl_pop, fl_rollback); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b want 0", init_done); end
    checks++; if (fl_data_in !== 6'd32) begin errors++; $display("FAIL reset_data_in: got %0d want 32", fl_data_in); end
    checks++; if (phys_rs1 !== 6'd5 || phys_rs2 !== 6'd17 || prev_phys_rd !== 6'd31) begin errors++; $display("FAIL reset_identity: got %0d/%0d/%0d want 5/17/31", phys_rs1, phys_rs2, prev_phys_rd); end
  endtask

  task automatic test_seeding();
    rst = 0; rename_uses_rd = 1; rename_rd = 5'd2;
    for (int i = 0; i < NP - NA; i++) begin
      #1;
      checks++; if (fl_push !== 1'b1 || fl_potential_push !== 1'b1) begin errors++; $display("FAIL seed_push[%0d]: got %b/%b want 1/1", i, fl_push, fl_potential_push); end
      checks++; if (fl_data_in !== PW'(NA + i)) begin errors++; $display("FAIL seed_data[%0d]: got %0d want %0d", i, fl_data_in, NA + i); end
      checks++; if (rename_ready !== 1'b0 || init_done !== 1'b0) begin errors++; $display("FAIL seed_ready[%0d]: got ready=%b done=%b want 0/0", i, rename_ready, init_done); end
      @(negedge clk);
    end
    #1;
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL seed_done: got %b want 1", init_done); end
    checks++; if (fl_push !== 1'b0) begin errors++; $display("FAIL seed_stop: got %b want 0", fl_push); end
    checks++; if (rename_ready !== 1'b1) begin errors++; $display("FAIL seed_ready_after: got %b want 1", rename_ready); end
    checks++; if (phys_rs1 !== 6'd5) begin errors++; $display("FAIL seed_lookup: got %0d want 5", phys_rs1); end
    idle();
  endtask

  task automatic test_rename_lookup();
    @(negedge clk); idle();
    rename_valid = 1; rename_uses_rd = 1; rename_rd = 5'd3; rename_rs1 = 5'd3; #1;
    checks++; if (rename_ready !== 1'b1 || fl_pop !== 1'b1) begin errors++; $display("FAIL rename_accept: got ready=%b pop=%b want 1/1", rename_ready, fl_pop); end
    checks++; if (phys_rd !== 6'd32) begin errors++; $display("FAIL rename_phys_rd: got %0d want 32", phys_rd); end
    checks++; if (prev_phys_rd !== 6'd3 || phys_rs1 !== 6'd3) begin errors++; $display("FAIL rename_old_map: got prev=%0d rs1=%0d want 3/3", prev_phys_rd, phys_rs1); end
    @(negedge clk); rename_valid = 0; #1;
    checks++; if (phys_rs1 !== 6'd32 || prev_phys_rd !== 6'd32) begin errors++; $display("FAIL rename_new_map: got rs1=%0d prev=%0d want 32/32", phys_rs1, prev_phys_rd); end
  endtask

  task automatic test_rollback();
    reset_and_seed();
    rename_valid = 1; rename_uses_rd = 1; rename_rd = 5'd3; #1;
    checks++; if (phys_rd !== 6'd32 || fl_pop !== 1'b1) begin errors++; $display("FAIL rb_rename: got rd=%0d pop=%b want 32/1", phys_rd, fl_pop); end
    @(negedge clk); rename_valid = 0; rollback = 1; #1;
    checks++; if (fl_rollback !== 1'b1 || rename_ready !== 1'b0) begin errors++; $display("FAIL rb_first: got rb=%b ready=%b want 1/0", fl_rollback, rename_ready); end
    @(negedge clk); #1;
    checks++; if (fl_rollback !== 1'b0) begin errors++; $display("FAIL rb_second: got %b want 0", fl_rollback); end
    @(negedge clk); rollback = 0; rename_rs1 = 5'd3; rename_valid = 1; rename_rd = 5'd7; #1;
    checks++; if (phys_rs1 !== 6'd3) begin errors++; $display("FAIL rb_restored: got %0d want 3", phys_rs1); end
    checks++; if (phys_rd !== 6'd32 || fl_pop !== 1'b1) begin errors++; $display("FAIL rb_realloc: got rd=%0d pop=%b want 32/1", phys_rd, fl_pop); end
    @(negedge clk); idle();
  endtask

  task automatic test_no_rd();
    rename_valid = 1; rename_uses_rd = 1; rename_rd = 5'd0; #1;
    checks++; if (fl_pop !== 1'b0 || phys_rd !== 6'd0 || rename_ready !== 1'b1) begin errors++; $display("FAIL nord_x0: got pop=%b rd=%0d ready=%b want 0/0/1", fl_pop, phys_rd, rename_ready); end
    @(negedge clk); rename_uses_rd = 0; rename_rd = 5'd9; #1;
    checks++; if (fl_pop !== 1'b0 || phys_rd !== 6'd0) begin errors++; $display("FAIL nord_nouse: got pop=%b rd=%0d want 0/0", fl_pop, phys_rd); end
    @(negedge clk); rename_valid = 0; rollback = 1; rename_rs1 = 5'd7; rename_rs2 = 5'd9; #1;
    checks++; if (fl_rollback !== 1'b0) begin errors++; $display("FAIL nord_rb: got %b want 0", fl_rollback); end
    @(negedge clk); rollback = 0; #1;
    checks++; if (phys_rs1 !== 6'd32 || phys_rs2 !== 6'd9) begin errors++; $display("FAIL nord_map: got %0d/%0d want 32/9", phys_rs1, phys_rs2); end
    idle();
  endtask

  task automatic test_exhaustion();
    reset_and_seed();
    for (int i = 0; i < NP - NA; i++) begin
      rename_valid = 1; rename_uses_rd = 1; rename_rd = 5'((i % 31) + 1); #1;
      checks++; if (rename_ready !== 1'b1 || fl_pop !== 1'b1 || phys_rd !== PW'(NA + i)) begin errors++; $display("FAIL exh_alloc[%0d]: got ready=%b pop=%b rd=%0d want 1/1/%0d", i, rename_ready, fl_pop, phys_rd, NA + i); end
      @(negedge clk);
    end
    rename_rd = 5'd4; #1;
    checks++; if (rename_ready !== 1'b0 || fl_pop !== 1'b0) begin errors++; $display("FAIL exh_stall: got ready=%b pop=%b want 0/0", rename_ready, fl_pop); end
    rename_uses_rd = 0; #1;
    checks++; if (rename_ready !== 1'b1) begin errors++; $display("FAIL exh_noalloc: got %b want 1", rename_ready); end
    @(negedge clk); rename_valid = 0; retire_valid = 1; retire_prev_phys_rd = 6'd3; #1;
    checks++; if (fl_push !== 1'b1 || fl_potential_push !== 1'b1 || fl_data_in !== 6'd3) begin errors++; $display("FAIL exh_retire: got push=%b pp=%b data=%0d want 1/1/3", fl_push, fl_potential_push, fl_data_in); end
    @(negedge clk); retire_valid = 0; rename_valid = 1; rename_uses_rd = 1; rename_rd = 5'd4; #1;
    checks++; if (rename_ready !== 1'b1 || phys_rd !== 6'd3) begin errors++; $display("FAIL exh_reuse: got ready=%b rd=%0d want 1/3", rename_ready, phys_rd); end
    @(negedge clk); idle();
  endtask

  task automatic test_simultaneous();
    retire_valid = 1; retire_prev_phys_rd = 6'd2;
    @(negedge clk); retire_valid = 0; rename_valid = 1; rename_uses_rd = 1; rename_rd = 5'd9; #1;
    checks++; if (phys_rd !== 6'd2 || prev_phys_rd !== 6'd40) begin errors++; $display("FAIL sim_rename: got rd=%0d prev=%0d want 2/40", phys_rd, prev_phys_rd); end
    @(negedge clk); rename_rd = 5'd10; rollback = 1; retire_valid = 1; retire_prev_phys_rd = 6'd5; #1;
    checks++; if (rename_ready !== 1'b0 || fl_pop !== 1'b0) begin errors++; $display("FAIL sim_blocked: got ready=%b pop=%b want 0/0", rename_ready, fl_pop); end
    checks++; if (fl_rollback !== 1'b1) begin errors++; $display("FAIL sim_rb: got %b want 1", fl_rollback); end
    checks++; if (fl_push !== 1'b1 || fl_data_in !== 6'd5) begin errors++; $display("FAIL sim_retire: got push=%b data=%0d want 1/5", fl_push, fl_data_in); end
    @(negedge clk); rollback = 0; retire_valid = 0; rename_rs1 = 5'd9; rename_rs2 = 5'd10; rename_rd = 5'd11; #1;
    checks++; if (phys_rs1 !== 6'd40 || phys_rs2 !== 6'd41) begin errors++; $display("FAIL sim_map: got %0d/%0d want 40/41", phys_rs1, phys_rs2); end
    checks++; if (phys_rd !== 6'd2 || fl_pop !== 1'b1) begin errors++; $display("FAIL sim_rewound: got rd=%0d pop=%b want 2/1", phys_rd, fl_pop); end
    @(negedge clk); idle();
  endtask

  task automatic test_random();
    reset_and_seed();
    for (int n = 0; n < 400; n++) begin
      rename_valid        = ($urandom_range(0, 3) != 0);
      rename_uses_rd      = ($urandom_range(0, 3) != 0);
      rename_rs1          = 5'($urandom_range(0, 31));
      rename_rs2          = 5'($urandom_range(0, 31));
      rename_rd           = 5'($urandom_range(0, 31));
      rollback            = ($urandom_range(0, 4) == 0);
      retire_valid        = (fl_count < 30) && ($urandom_range(0, 2) == 0);
      retire_prev_phys_rd = 6'($urandom_range(0, 63));
      #1;
      checks++; if (phys_rs1 !== exp_rs1 || phys_rs2 !== exp_rs2) begin errors++; $display("FAIL rnd_src[%0d]: got %0d/%0d want %0d/%0d", n, phys_rs1, phys_rs2, exp_rs1, exp_rs2); end
      checks++; if (prev_phys_rd !== exp_prev || phys_rd !== exp_prd) begin errors++; $display("FAIL rnd_dst[%0d]: got prev=%0d rd=%0d want %0d/%0d", n, prev_phys_rd, phys_rd, exp_prev, exp_prd); end
      checks++; if (rename_ready !== exp_ready || fl_pop !== exp_pop) begin errors++; $display("FAIL rnd_hs[%0d]: got ready=%b pop=%b want %b/%b", n, rename_ready, fl_pop, exp_ready, exp_pop); end
      checks++; if (fl_rollback !== exp_rb) begin errors++; $display("FAIL rnd_rb[%0d]: got %b want %b", n, fl_rollback, exp_rb); end
      checks++; if (fl_push !== exp_push || fl_potential_push !== exp_push) begin errors++; $display("FAIL rnd_push[%0d]: got %b/%b want %b", n, fl_push, fl_potential_push, exp_push); end
      if (exp_push) begin
        checks++; if (fl_data_in !== exp_din) begin errors++; $display("FAIL rnd_din[%0d]: got %0d want %0d", n, fl_data_in, exp_din); end
      end
      checks++; if (init_done !== exp_init_done) begin errors++; $display("FAIL rnd_done[%0d]: got %b want %b", n, init_done, exp_init_done); end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_mid_reset();
    rst = 1; rename_rs1 = 5'd17;
    @(negedge clk); #1;
    checks++; if (rename_ready !== 1'b0 || fl_push !== 1'b0 || fl_pop !== 1'b0 || fl_rollback !== 1'b0) begin errors++; $display("FAIL mid_outputs: got %b%b%b%b want 0000", rename_ready, fl_push, fl_pop, fl_rollback); end
    checks++; if (init_done !== 1'b0 || fl_data_in !== 6'd32 || phys_rs1 !== 6'd17) begin errors++; $display("FAIL mid_state: got done=%b din=%0d rs1=%0d want 0/32/17", init_done, fl_data_in, phys_rs1); end
    rst = 0; #1;
    checks++; if (fl_push !== 1'b1 || fl_data_in !== 6'd32) begin errors++; $display("FAIL mid_reseed: got push=%b din=%0d want 1/32", fl_push, fl_data_in); end
    repeat (NP - NA) @(negedge clk);
    #1;
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL mid_done: got %b want 1", init_done); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_seeding();
    test_rename_lookup();
    test_rollback();
    test_no_rd();
    test_exhaustion();
    test_simultaneous();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
